// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display logic: FSM states,
// digit count, blank codes and the active-low hex segment table.
package seg7_pkg;

    localparam int NDIG = 8;

    // Active-low blank codes
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic [1:0] {
        LOAD,
        SHOW,
        GUARD
    } state_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-low, indexed by nibble value
    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        7'b0001000, // A
        7'b0000011, // b
        7'b1000110, // C
        7'b0100001, // d
        7'b0000110, // E
        7'b0001110  // F
    };

endpackage

// File: rtl/seg7_scan_if.sv
// Display bus: the value to show flows in, the multiplexed drive and the
// frame pulse flow out. master = value producer / observer, slave = scanner.
interface seg7_scan_if;
    logic [31:0] disp;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        frame_done;

    modport master (output disp, input an, input seg, input frame_done);
    modport slave  (input disp, output an, output seg, output frame_done);
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit to active-low seven-segment decode.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup; the table lives in the package so other display logic shares it
    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner (common anode, active-low).
// A snapshot of disp is taken once per frame so digits never tear; each digit
// is lit for CLK_DIV cycles followed by a one-cycle all-off guard.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter logic [16:0] CLK_DIV = 17'd100000
)
(
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);

    localparam logic [16:0] DIV_LAST = CLK_DIV - 17'd1;
    localparam logic [2:0]  IDX_LAST = 3'(NDIG - 1);

    state_t      state_reg;
    logic [31:0] snapshot_reg;
    logic [2:0]  idx_reg;
    logic [16:0] div_reg;
    logic [7:0]  an_reg;
    logic [6:0]  seg_reg;
    logic        frame_done_reg;
    logic [7:0]  blank_reg;
    logic [7:0]  blank_next;
    logic [3:0]  cur_nib;
    logic [6:0]  cur_seg;

    // Digit 0 is never blanked so an all-zero value still shows "0"
    assign blank_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NDIG; gi++) begin : g_blank
`ifdef SEG7_LZB_EN
            // Blank digit gi when it and every digit above it are zero
            assign blank_next[gi] = (bus.disp[31:4*gi] == '0);
`else
            assign blank_next[gi] = 1'b0;
`endif
        end
    endgenerate

    assign cur_nib = snapshot_reg[{idx_reg, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .hex (cur_nib),
        .seg (cur_seg)
    );

    // Scan FSM with registered drive outputs that reflect the state one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= LOAD;
            snapshot_reg   <= '0;
            idx_reg        <= '0;
            div_reg        <= '0;
            blank_reg      <= '0;
            an_reg         <= AN_OFF;
            seg_reg        <= SEG_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            an_reg         <= AN_OFF;
            seg_reg        <= SEG_OFF;
            frame_done_reg <= 1'b0;
            unique case (state_reg)
                LOAD: begin
                    snapshot_reg   <= bus.disp;
                    blank_reg      <= blank_next;
                    idx_reg        <= '0;
                    div_reg        <= '0;
                    frame_done_reg <= 1'b1;
                    state_reg      <= SHOW;
                end
                SHOW: begin
                    if (!blank_reg[idx_reg]) begin
                        an_reg  <= ~(8'b1 << idx_reg);
                        seg_reg <= cur_seg;
                    end
                    if (div_reg == DIV_LAST) begin
                        div_reg   <= '0;
                        state_reg <= GUARD;
                    end else begin
                        div_reg <= div_reg + 17'd1;
                    end
                end
                GUARD: begin
                    if (idx_reg == IDX_LAST) begin
                        state_reg <= LOAD;
                    end else begin
                        idx_reg   <= idx_reg + 3'd1;
                        state_reg <= SHOW;
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign bus.an         = an_reg;
    assign bus.seg        = seg_reg;
    assign bus.frame_done = frame_done_reg;

endmodule
